rh_axi4_wr_slave: RTL and testbench
===================================

Name: rh_axi4_wr_slave

Overview:
Synthesizable AXI4 write-channel slave: accepts AW/W bursts, writes a local word memory, returns B responses. Sits directly downstream of the AXI4 master driver: the DUT endpoint that the master agent's write traffic terminates in. Debug read port gives the bench direct memory visibility for scoreboarding. Single outstanding write; no read channels.

Parameters:
ADDR_W, 32, AWADDR width
DATA_W, 32, WDATA width (32 or 64); STRB_W = DATA_W/8
ID_W, 4, AWID/BID width
MEM_DEPTH, 256, memory depth in DATA_W words
BASE_ADDR, 0, byte address of word 0 (DATA_W/8 aligned)

Ports:
ACLK  in  1  clock, rising edge
ARESET  in  1  asynchronous, active-high reset
AWID  in  ID_W  write ID
AWADDR  in  ADDR_W  start byte address
AWLEN  in  8  beats-1
AWSIZE  in  3  log2 bytes per beat
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
AWVALID  in  1  address valid
AWREADY  out  1  address ready
WDATA  in  DATA_W  write data
WSTRB  in  STRB_W  byte enables
WLAST  in  1  last beat
WVALID  in  1  data valid
WREADY  out  1  data ready
BID  out  ID_W  response ID (= captured AWID)
BRESP  out  2  00 OKAY, 10 SLVERR
BVALID  out  1  response valid
BREADY  in  1  response ready
dbg_addr  in  $clog2(MEM_DEPTH)  debug word index
dbg_data  out  DATA_W  combinational mem[dbg_addr]

Behaviour:
- Reset (async assert, sync-released by ACLK): state=IDLE, AWREADY=0 until first edge after release then 1, WREADY=0, BVALID=0, BID=0, BRESP=0. Memory not reset.
- FSM IDLE -> DATA -> RESP -> IDLE. Outputs registered.
- IDLE: AWREADY=1. On AWVALID&AWREADY: capture id/addr/len/size/burst, beat_cnt=0, err per rules below; AWREADY=0, WREADY=1 next cycle, go DATA. W beats arriving in IDLE are not accepted (WREADY=0).
- DATA: WREADY=1 (zero-bubble, one beat per cycle). Each W handshake: if !err and word in range, write bytes of WDATA where WSTRB=1 to word (addr-BASE_ADDR)>>log2(STRB_W); update addr; beat_cnt++. Beat with beat_cnt==AWLEN ends burst: WREADY=0, BVALID=1, BID=id next cycle, go RESP.
- Burst length set by AWLEN only. WLAST=1 on beat_cnt<AWLEN, or WLAST=0 on final beat -> sticky err (that beat still written if otherwise legal).
- Address update: FIXED unchanged; INCR addr=(addr & ~((1<<size)-1)) + (1<<size); WRAP bound=(AWLEN+1)<<size, addr=(addr & ~(bound-1)) | ((addr+(1<<size)) & (bound-1)). Arithmetic in ADDR_W bits, wraps modulo 2^ADDR_W.
- err at AW (whole burst SLVERR, no writes, all beats still accepted): AWSIZE>log2(STRB_W); AWBURST=11; WRAP with AWLEN not in {1,3,7,15}; WRAP with AWADDR not size-aligned.
- Per-beat: word index >= MEM_DEPTH or addr<BASE_ADDR -> beat dropped, sticky err. Other beats of burst still written.
- RESP: BRESP=err?10:00. Hold BVALID/BID/BRESP stable until BREADY; on BVALID&BREADY: BVALID=0, AWREADY=1 next cycle, go IDLE. Earliest new AW handshake one cycle after B handshake.
- Reset mid-burst: immediate return to IDLE values; in-flight burst abandoned, no B response; beats already written stay in memory.
- dbg_data combinational, reflects writes from the cycle after the write edge.

Test Plan:
- INCR AWADDR=0x10, AWLEN=3, SIZE=2, WDATA 0xA0..0xA3, WSTRB=F, WLAST on beat 3 -> mem[4..7]=0xA0..0xA3, BRESP=00, BID=AWID, BVALID 1 cycle after last W.
- WRAP AWADDR=0x38, AWLEN=3, SIZE=2 -> writes to words 14,15,12,13; BRESP=00.
- FIXED AWADDR=0x8, AWLEN=2, WSTRB 0x1,0x2,0xC data 0x11,0x2200,0x33440000 -> mem[2]=0x33442211.
- Errors: AWSIZE=3 on DATA_W=32 -> all beats accepted, mem unchanged, BRESP=10; INCR at word 254 AWLEN=3 -> words 254,255 written, BRESP=10; WLAST early on beat 1 of AWLEN=3 -> 4 beats taken, BRESP=10.
- Backpressure: BREADY low 5 cycles -> BVALID/BRESP/BID stable, AWREADY=0 throughout; WVALID gaps -> beats counted only on handshake.
- Assert ARESET during beat 2 of 4 -> WREADY=0, BVALID never asserts, AWREADY=1 after release; beats 0-1 present in memory.

Source files
------------

// File: rtl/rh_axi4_wr_slave.sv
// AXI4 write-channel slave: takes one AW/W burst at a time, writes a local word
// memory and returns a single B response. A debug port reads the memory directly.
module rh_axi4_wr_slave #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W = 4,
  parameter int MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  localparam int STRB_W = DATA_W / 8,
  localparam int IDX_W = $clog2(MEM_DEPTH)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [7:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int LSB = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  state_e state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              aw_err_q, aw_err_d;
  logic              err_q, err_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic              aw_hs, w_hs, b_hs, last_beat;
  logic              aw_bad, wlast_bad, in_range, wr_en;
  logic [ADDR_W-1:0] aw_mask, step, bound, next_addr, offset, widx;

  assign aw_hs     = AWVALID & awready_q;
  assign w_hs      = WVALID & wready_q;
  assign b_hs      = BREADY & bvalid_q;
  assign last_beat = (beat_cnt_q == len_q);
  assign wlast_bad = (WLAST != last_beat);

  // Burst-level faults are judged once at AW time and suppress every write.
  always_comb begin
    aw_mask = (ADDR_W'(1) << AWSIZE) - ADDR_W'(1);
    aw_bad  = (AWSIZE > 3'(LSB)) || (AWBURST == 2'b11);
    if (AWBURST == 2'b10) begin
      if (!(AWLEN == 8'd1 || AWLEN == 8'd3 || AWLEN == 8'd7 || AWLEN == 8'd15))
        aw_bad = 1'b1;
      if ((AWADDR & aw_mask) != '0)
        aw_bad = 1'b1;
    end
  end

  always_comb begin
    step  = ADDR_W'(1) << size_q;
    bound = (ADDR_W'(len_q) + ADDR_W'(1)) << size_q;
    case (burst_q)
      2'b01:   next_addr = (addr_q & ~(step - ADDR_W'(1))) + step;
      2'b10:   next_addr = (addr_q & ~(bound - ADDR_W'(1))) |
                           ((addr_q + step) & (bound - ADDR_W'(1)));
      default: next_addr = addr_q;
    endcase
    offset   = addr_q - BASE_ADDR;
    widx     = offset >> LSB;
    in_range = (addr_q >= BASE_ADDR) && (widx < ADDR_W'(MEM_DEPTH));
    wr_en    = (state_q == DATA) && w_hs && !aw_err_q && in_range;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
      aw_err_q   <= 1'b0;
      err_q      <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      aw_err_q   <= aw_err_d;
      err_q      <= err_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aw_hs) state_d = DATA;
      DATA:    if (w_hs && last_beat) state_d = RESP;
      RESP:    if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst context: captured on AW, advanced on each W handshake.
  always_comb begin
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    aw_err_d   = aw_err_q;
    err_d      = err_q;
    if (state_q == IDLE && aw_hs) begin
      id_d       = AWID;
      addr_d     = AWADDR;
      len_d      = AWLEN;
      size_d     = AWSIZE;
      burst_d    = AWBURST;
      beat_cnt_d = '0;
      aw_err_d   = aw_bad;
      err_d      = aw_bad;
    end else if (state_q == DATA && w_hs) begin
      addr_d     = next_addr;
      beat_cnt_d = beat_cnt_q + 8'd1;
      err_d      = err_q | wlast_bad | !in_range;
    end
  end

  always_comb begin
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    case (state_q)
      IDLE: begin
        awready_d = !aw_hs;
        wready_d  = aw_hs;
      end
      DATA: begin
        if (w_hs && last_beat) begin
          wready_d = 1'b0;
          bvalid_d = 1'b1;
          bid_d    = id_q;
          bresp_d  = err_d ? 2'b10 : 2'b00;
        end
      end
      RESP: begin
        if (b_hs) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b])
          mem[widx[IDX_W-1:0]][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  assign AWREADY  = awready_q;
  assign WREADY   = wready_q;
  assign BVALID   = bvalid_q;
  assign BID      = bid_q;
  assign BRESP    = bresp_q;
  assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_rh_axi4_wr_slave.sv
// Randomized and directed bench for rh_axi4_wr_slave, scored against a
// burst-level memory model computed from the AXI4 address rules.
module tb_rh_axi4_wr_slave;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int ID_W = 4;
   localparam int MEM_DEPTH = 256;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [3:0]  AWID;
   logic [31:0] AWADDR;
   logic [7:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WLAST;
   logic        WVALID;
   logic        WREADY;
   logic [3:0]  BID;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [7:0]  dbgAddr;
   logic [31:0] dbgData;

   rh_axi4_wr_slave #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR('0)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .dbg_addr(dbgAddr), .dbg_data(dbgData)
   );

   always #5 ACLK = ~ACLK;

   int checks = 0;
   int errors = 0;

   // Current burst description shared by the driver and the model.
   logic [3:0]  bId;
   logic [31:0] bAddr;
   logic [7:0]  bLen;
   logic [2:0]  bSize;
   logic [1:0]  bBurst;
   logic [31:0] bData [256];
   logic [3:0]  bStrb [256];
   logic        bLast [256];
   int          bGap [256];
   int          bReadyDelay;

   logic [31:0] modelMem [MEM_DEPTH];

   // Every comparison funnels through here so the counters stay honest.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Address of the beat after 'a', using modular arithmetic instead of masks.
   function automatic logic [31:0] nextAddr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst, input logic [7:0] len);
      longint step;
      longint bound;
      longint base;
      step  = longint'(1) << size;
      bound = (longint'(len) + 1) * step;
      case (burst)
         2'b01: return 32'((longint'(a) - (longint'(a) % step)) + step);
         2'b10: begin
            base = longint'(a) - (longint'(a) % bound);
            return 32'(base + ((longint'(a) + step) % bound));
         end
         default: return a;
      endcase
   endfunction

   // Applies the first nBeats of the current burst to the model memory.
   task automatic modelBurst(input int nBeats, output logic [1:0] resp);
      logic [31:0] a;
      bit err;
      bit awBad;
      int idx;
      a = bAddr;
      awBad = (bSize > 3'd2) || (bBurst == 2'b11) ||
              (bBurst == 2'b10 && !(bLen inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
              (bBurst == 2'b10 && (bAddr % (32'd1 << bSize)) != 0);
      err = awBad;
      for (int i = 0; i < nBeats; i++) begin
         if (bLast[i] != (i == int'(bLen))) err = 1'b1;
         idx = int'(a / 4);
         if (idx >= MEM_DEPTH) err = 1'b1;
         else if (!awBad) begin
            for (int k = 0; k < 4; k++)
               if (bStrb[i][k]) modelMem[idx][8*k +: 8] = bData[i][8*k +: 8];
         end
         a = nextAddr(a, bSize, bBurst, bLen);
      end
      resp = err ? 2'b10 : 2'b00;
   endtask

   task automatic setBurst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
      bId = id; bAddr = addr; bLen = len; bSize = size; bBurst = burst;
      bReadyDelay = 0;
      for (int i = 0; i < 256; i++) begin
         bData[i] = $urandom;
         bStrb[i] = 4'hF;
         bLast[i] = (i == int'(len));
         bGap[i]  = 0;
      end
   endtask

   task automatic awPhase();
      int cnt;
      AWID = bId; AWADDR = bAddr; AWLEN = bLen; AWSIZE = bSize; AWBURST = bBurst;
      AWVALID = 1'b1;
      cnt = 0;
      while (AWREADY !== 1'b1 && cnt < 20) begin
         @(posedge ACLK); #1;
         cnt++;
      end
      checkOutput("awready_wait", AWREADY, 1);
      @(posedge ACLK); #1;
      AWVALID = 1'b0;
      checkOutput("wready_after_aw", WREADY, 1);
   endtask

   task automatic sendBeat(input int i);
      repeat (bGap[i]) begin @(posedge ACLK); #1; end
      WDATA = bData[i]; WSTRB = bStrb[i]; WLAST = bLast[i]; WVALID = 1'b1;
      @(posedge ACLK); #1;
      WVALID = 1'b0; WLAST = 1'b0;
   endtask

   // Drives the whole current burst and checks the handshake timing and response.
   task automatic applyStimulus();
      logic [1:0] expResp;
      modelBurst(int'(bLen) + 1, expResp);
      awPhase();
      for (int i = 0; i <= int'(bLen); i++) begin
         sendBeat(i);
         if (i < int'(bLen)) checkOutput("bvalid_early", BVALID, 0);
      end
      checkOutput("bvalid_after_last", BVALID, 1);
      checkOutput("wready_after_last", WREADY, 0);
      checkOutput("bid", BID, bId);
      checkOutput("bresp", BRESP, expResp);
      repeat (bReadyDelay) begin
         @(posedge ACLK); #1;
         checkOutput("bvalid_hold", BVALID, 1);
         checkOutput("bid_hold", BID, bId);
         checkOutput("bresp_hold", BRESP, expResp);
         checkOutput("awready_in_resp", AWREADY, 0);
      end
      BREADY = 1'b1;
      @(posedge ACLK); #1;
      BREADY = 1'b0;
      checkOutput("bvalid_cleared", BVALID, 0);
      checkOutput("awready_after_b", AWREADY, 1);
   endtask

   task automatic checkMemory();
      for (int i = 0; i < MEM_DEPTH; i++) begin
         dbgAddr = 8'(i);
         #1;
         checkOutput($sformatf("mem[%0d]", i), dbgData, modelMem[i]);
      end
   endtask

   initial begin
      logic [1:0] dummyResp;
      int r;
      ARESET = 1'b1;
      AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; dbgAddr = '0;
      #1;
      checkOutput("rst_awready", AWREADY, 0);
      checkOutput("rst_wready", WREADY, 0);
      checkOutput("rst_bvalid", BVALID, 0);
      checkOutput("rst_bid", BID, 0);
      checkOutput("rst_bresp", BRESP, 0);
      repeat (3) @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      checkOutput("awready_before_edge", AWREADY, 0);
      @(posedge ACLK); #1;
      checkOutput("awready_after_release", AWREADY, 1);

      $display("[TB] filling memory");
      for (int k = 0; k < 16; k++) begin
         setBurst(4'(k), 32'(k * 64), 8'd15, 3'd2, 2'b01);
         applyStimulus();
      end
      checkMemory();

      $display("[TB] directed INCR / WRAP / FIXED");
      setBurst(4'd5, 32'h10, 8'd3, 3'd2, 2'b01);
      for (int i = 0; i < 4; i++) bData[i] = 32'hA0 + 32'(i);
      applyStimulus();
      setBurst(4'd6, 32'h38, 8'd3, 3'd2, 2'b10);
      applyStimulus();
      setBurst(4'd7, 32'h8, 8'd2, 3'd2, 2'b00);
      bData[0] = 32'h11; bData[1] = 32'h2200; bData[2] = 32'h33440000;
      bStrb[0] = 4'h1; bStrb[1] = 4'h2; bStrb[2] = 4'hC;
      applyStimulus();
      dbgAddr = 8'd2; #1;
      checkOutput("fixed_merge", dbgData, 32'h33442211);
      checkMemory();

      $display("[TB] directed error bursts");
      setBurst(4'd8, 32'h40, 8'd3, 3'd3, 2'b01);
      applyStimulus();
      setBurst(4'd9, 32'h3F8, 8'd3, 3'd2, 2'b01);
      applyStimulus();
      setBurst(4'd10, 32'h100, 8'd3, 3'd2, 2'b01);
      bLast[1] = 1'b1;
      applyStimulus();
      checkMemory();

      $display("[TB] backpressure");
      setBurst(4'd11, 32'h200, 8'd3, 3'd2, 2'b01);
      bReadyDelay = 5;
      bGap[1] = 2; bGap[3] = 1;
      applyStimulus();
      checkMemory();

      $display("[TB] reset mid-burst");
      setBurst(4'd3, 32'h80, 8'd3, 3'd2, 2'b01);
      modelBurst(2, dummyResp);
      awPhase();
      sendBeat(0);
      sendBeat(1);
      WDATA = bData[2]; WSTRB = 4'hF; WVALID = 1'b1;
      #1 ARESET = 1'b1;
      #1;
      checkOutput("midrst_wready", WREADY, 0);
      checkOutput("midrst_bvalid", BVALID, 0);
      checkOutput("midrst_awready", AWREADY, 0);
      WVALID = 1'b0;
      repeat (2) @(posedge ACLK);
      #1 ARESET = 1'b0;
      @(posedge ACLK); #1;
      checkOutput("midrst_awready_after", AWREADY, 1);
      repeat (5) @(posedge ACLK);
      #1;
      checkOutput("midrst_no_b", BVALID, 0);
      checkMemory();

      $display("[TB] random bursts");
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         setBurst(4'($urandom), 32'($urandom_range(0, 1100)), 8'($urandom_range(0, 15)),
                  3'($urandom_range(0, 2)), (r < 3) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11);
         if ($urandom_range(0, 9) == 0) bSize = 3'd3;
         if (bBurst == 2'b10) begin
            if ($urandom_range(0, 7) != 0) bLen = 8'((2 << $urandom_range(0, 3)) - 1);
            if ($urandom_range(0, 7) != 0) bAddr = bAddr & ~((32'd1 << bSize) - 1);
         end
         for (int i = 0; i <= int'(bLen); i++) begin
            bLast[i] = (i == int'(bLen));
            bStrb[i] = 4'($urandom);
            bGap[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
         end
         if ($urandom_range(0, 9) == 0) begin
            r = $urandom_range(0, int'(bLen));
            bLast[r] = ~bLast[r];
         end
         bReadyDelay = $urandom_range(0, 3);
         applyStimulus();
      end
      checkMemory();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
